// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: divided pixel clock, sync/data-enable, scaled framebuffer address.
// Define VGA_TIMING_DOUBLE_BUFFER_EN for front/back base selection swapped at vblank entry.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned HSYNC_POL   = 0,
  parameter int unsigned VSYNC_POL   = 0,
  parameter int unsigned CLOCK_DIV   = 2,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_WIDTH  = 17
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [ADDR_WIDTH-1:0] i_base,
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
  input  logic                  i_swap,
  output logic                  o_front_sel,
`endif
  output logic                  o_vga_clock,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_data_enable,
  output logic [ADDR_WIDTH-1:0] o_vga_address,
  output logic                  o_frame_start,
  output logic                  o_line_start,
  output logic                  o_vblank
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW           = $clog2(H_TOTAL);
  localparam int unsigned VW           = $clog2(V_TOTAL);
  localparam int unsigned DW           = $clog2(CLOCK_DIV);
  localparam int unsigned DIV_HALF     = CLOCK_DIV / 2;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned LINE_STRIDE  = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned SCALE_MASK   = (1 << SCALE_SHIFT) - 1;
  localparam logic        HS_ON        = 1'(HSYNC_POL);
  localparam logic        VS_ON        = 1'(VSYNC_POL);

  logic [DW-1:0]         div_cnt;
  logic [DW-1:0]         div_next;
  logic                  tick;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [VW-1:0]         v_inc;
  logic [31:0]           h_pos;
  logic [31:0]           v_pos;
  logic                  h_last;
  logic                  v_last;
  logic                  h_vis;
  logic                  v_vis;
  logic                  hs_on;
  logic                  vs_on;
  logic                  frame_origin;
  logic                  stride_step;
  logic [ADDR_WIDTH-1:0] line_off;
  logic [ADDR_WIDTH-1:0] base_latched;
  logic [ADDR_WIDTH-1:0] frame_base;
  logic [ADDR_WIDTH-1:0] pix_addr;

`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
  logic                  swap_req;
  logic                  swap_now;
  logic [ADDR_WIDTH-1:0] front_base;
`endif

  // Position decode and address formation for the current pixel
  always_comb begin
    tick         = div_cnt == DW'(CLOCK_DIV - 1);
    div_next     = tick ? '0 : div_cnt + DW'(1);
    h_pos        = 32'(h_cnt);
    v_pos        = 32'(v_cnt);
    h_last       = h_pos == H_TOTAL - 1;
    v_last       = v_pos == V_TOTAL - 1;
    v_inc        = v_cnt + VW'(1);
    stride_step  = (v_inc & VW'(SCALE_MASK)) == '0;
    h_vis        = h_pos < H_ACTIVE;
    v_vis        = v_pos < V_ACTIVE;
    hs_on        = (h_pos >= H_SYNC_START) && (h_pos < H_SYNC_END);
    vs_on        = (v_pos >= V_SYNC_START) && (v_pos < V_SYNC_END);
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
    frame_base   = front_base;
    swap_now     = tick && (h_cnt == '0) && (v_pos == V_ACTIVE) && swap_req;
`else
    frame_base   = i_base;
`endif
    // At (0,0) the base register is being loaded this tick, so bypass it
    pix_addr     = (frame_origin ? frame_base : base_latched)
                 + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT) + line_off;
  end

  // System-clock divider and pixel clock
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt     <= '0;
      o_vga_clock <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      o_vga_clock <= 32'(div_next) >= DIV_HALF;
    end
  end

  // Raster counters and line-base accumulator (one stride every 2^SCALE_SHIFT lines)
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      line_off <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt    <= '0;
          line_off <= '0;
        end else begin
          v_cnt <= v_inc;
          if (stride_step) begin
            line_off <= line_off + ADDR_WIDTH'(LINE_STRIDE);
          end
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Video outputs: updated on the tick, held between ticks
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hsync       <= ~HS_ON;
      o_vsync       <= ~VS_ON;
      o_data_enable <= 1'b0;
      o_vblank      <= 1'b0;
      o_vga_address <= '0;
      base_latched  <= '0;
    end else if (tick) begin
      o_hsync       <= hs_on ? HS_ON : ~HS_ON;
      o_vsync       <= vs_on ? VS_ON : ~VS_ON;
      o_data_enable <= h_vis && v_vis;
      o_vblank      <= !v_vis;
      if (h_vis && v_vis) begin
        o_vga_address <= pix_addr;
      end
      if (frame_origin) begin
        base_latched <= frame_base;
      end
    end
  end

  // Single-system-clock strobes for the video DMA
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
    end else begin
      o_frame_start <= tick && frame_origin;
      o_line_start  <= tick && (h_cnt == '0) && v_vis;
    end
  end

`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
  // Swap request honoured at vblank entry; a request during the honour cycle waits a frame
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      swap_req    <= 1'b0;
      front_base  <= '0;
      o_front_sel <= 1'b0;
    end else begin
      swap_req <= (swap_req && !swap_now) || i_swap;
      if (swap_now) begin
        front_base  <= i_base;
        o_front_sel <= ~o_front_sel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster: pixel-index model plus directed literals.
// Honours VGA_TIMING_DOUBLE_BUFFER_EN when defined for both DUT and bench.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int D = 4, S = 1, AW = 10, HP = 1, VP = 0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam bit HS_LVL = 1'(HP);
  localparam bit VS_LVL = 1'(VP);
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_base = '0;
  logic          o_vga_clock, o_hsync, o_vsync, o_data_enable;
  logic [AW-1:0] o_vga_address;
  logic          o_frame_start, o_line_start, o_vblank;
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
  logic          i_swap = 1'b0;
  logic          o_front_sel;
  int            m_front = 0;
  bit            m_sel = 1'b0;
  bit            m_req = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n = 0;          // system-clock edges since reset release
  int m_fbase = 0;    // base sampled at the start of the current frame

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CLOCK_DIV(D), .SCALE_SHIFT(S), .ADDR_WIDTH(AW)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_base(i_base),
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
    .i_swap(i_swap),
    .o_front_sel(o_front_sel),
`endif
    .o_vga_clock(o_vga_clock),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_data_enable(o_data_enable),
    .o_vga_address(o_vga_address),
    .o_frame_start(o_frame_start),
    .o_line_start(o_line_start),
    .o_vblank(o_vblank)
  );

  // Raster index of the pixel registered at edge e (valid when e is a tick edge)
  function automatic int pix_of(input int e);
    return (e / D - 1) % TOT;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int fb, input int h, input int v);
    return AW'(fb + (h >> S) + (v >> S) * (HA >> S));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference state: edge count, per-frame base and swap bookkeeping
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 0;
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
      m_front <= 0;
      m_sel   <= 1'b0;
      m_req   <= 1'b0;
`endif
    end else begin
      n <= n + 1;
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
      if ((n + 1) % D == 0 && pix_of(n + 1) == 0) m_fbase <= m_front;
      if ((n + 1) % D == 0 && pix_of(n + 1) == VA * HT && m_req) begin
        m_front <= int'(i_base);
        m_sel   <= !m_sel;
      end
      m_req <= (m_req && !((n + 1) % D == 0 && pix_of(n + 1) == VA * HT)) || i_swap;
`else
      if ((n + 1) % D == 0 && pix_of(n + 1) == 0) m_fbase <= int'(i_base);
`endif
    end
  end

  task automatic compare_cycle();
    int t, p, h, v, ah, av;
    logic e_clk, e_hs, e_vs, e_de, e_vb, e_fs, e_ls;
    logic [AW-1:0] e_addr;
    t = n / D;
    e_clk = (n % D) >= D / 2;
    if (t == 0) begin
      e_hs = !HS_LVL; e_vs = !VS_LVL; e_de = 1'b0; e_vb = 1'b0;
      e_fs = 1'b0; e_ls = 1'b0; e_addr = '0;
    end else begin
      p = (t - 1) % TOT;
      h = p % HT;
      v = p / HT;
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HF && h < HA + HF + HS) ? HS_LVL : !HS_LVL;
      e_vs = (v >= VA + VF && v < VA + VF + VS) ? VS_LVL : !VS_LVL;
      e_vb = v >= VA;
      e_fs = (n % D == 0) && (p == 0);
      e_ls = (n % D == 0) && (h == 0) && (v < VA);
      if (v >= VA) begin ah = HA - 1; av = VA - 1; end
      else if (h >= HA) begin ah = HA - 1; av = v; end
      else begin ah = h; av = v; end
      e_addr = addr_of(m_fbase, ah, av);
    end
    chk("vga_clock", o_vga_clock, e_clk);
    chk("hsync", o_hsync, e_hs);
    chk("vsync", o_vsync, e_vs);
    chk("data_enable", o_data_enable, e_de);
    chk("vblank", o_vblank, e_vb);
    chk("frame_start", o_frame_start, e_fs);
    chk("line_start", o_line_start, e_ls);
    chk("vga_address", o_vga_address, e_addr);
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
    chk("front_sel", o_front_sel, m_sel);
`endif
  endtask

  always @(negedge clk) compare_cycle();

  task automatic wait_fs(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_frame_start) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  // Advance to the negedge where pixel p (relative to the observed frame start) is visible
  task automatic goto_p(input int p, inout int k);
    while (k < p * D) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    int base0;
    bit seen;
    base0 = DB ? 0 : 'h100;
    i_base = AW'('h100);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", o_hsync, !HS_LVL);
    chk("rst_vsync", o_vsync, !VS_LVL);
    chk("rst_addr", o_vga_address, 0);
    rst_n = 1'b1;

    wait_fs(2 * D + 2, seen);
    chk("first_frame_start_seen", seen, 1);
    k = 0;
    chk("p0_addr", o_vga_address, base0);
    chk("p0_de", o_data_enable, 1);
    goto_p(2, k);   chk("p2_addr", o_vga_address, base0 + 1);
    goto_p(7, k);   chk("p7_addr", o_vga_address, base0 + 3);
    goto_p(8, k);   chk("p8_de", o_data_enable, 0);
                    chk("p8_addr_hold", o_vga_address, base0 + 3);
    goto_p(10, k);  chk("p10_hsync_on", o_hsync, HS_LVL);
    goto_p(12, k);  chk("p12_hsync_off", o_hsync, !HS_LVL);
    goto_p(14, k);  chk("line1_addr", o_vga_address, base0);
                    chk("line1_start", o_line_start, 1);
    goto_p(20, k);
    i_base = AW'('h200);
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
    i_swap = 1'b1;
`endif
    @(negedge clk);
    k++;
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
    i_swap = 1'b0;
`endif
    goto_p(28, k);  chk("line2_addr", o_vga_address, base0 + 4);
    goto_p(30, k);  chk("midframe_base_unchanged", o_vga_address, base0 + 5);
    goto_p(56, k);  chk("vblank_on", o_vblank, 1);
                    chk("vblank_addr_hold", o_vga_address, base0 + 7);
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
                    chk("swap_at_vblank", o_front_sel, 1);
`endif
    goto_p(70, k);  chk("vsync_on", o_vsync, VS_LVL);
    goto_p(84, k);  chk("vsync_off", o_vsync, !VS_LVL);
    goto_p(TOT, k); chk("frame_period", o_frame_start, 1);
                    chk("new_frame_base", o_vga_address, 'h200);
    goto_p(TOT + HT + 3, k);
    chk("pre_reset_addr", o_vga_address, 'h201);
    chk("pre_reset_de", o_data_enable, 1);

    // Asynchronous reset mid-line, away from any clock edge
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_de", o_data_enable, 0);
    chk("async_rst_addr", o_vga_address, 0);
    chk("async_rst_vga_clock", o_vga_clock, 0);
    chk("async_rst_hsync", o_hsync, !HS_LVL);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fs(2 * D + 2, seen);
    chk("post_reset_frame_start", seen, 1);
    chk("post_reset_addr", o_vga_address, DB ? 0 : 'h200);

    // Randomised base changes, swap requests and reset pulses
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) i_base = AW'($urandom);
`ifdef VGA_TIMING_DOUBLE_BUFFER_EN
      i_swap = $urandom_range(0, 99) < 2;
`endif
      if (i == 1500 || i == 2900) begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
